// File: rtl/toggle_mon_pkg.sv
// Shared types and sizing helpers for the toggle activity monitor.
package toggle_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        COUNT,
        DRAIN
    } state_t;

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic [63:0] sat_max(input int cnt_w);
        return (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Single saturating up-counter with synchronous reset and clear.
module sat_counter
    import toggle_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [63:0] MAX64 = sat_max(CNT_W);
    localparam logic [CNT_W-1:0] MAX = MAX64[CNT_W-1:0];

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/toggle_activity_monitor.sv
// Per-bit toggle counter over a sample window, streamed out one bit per beat.
// Optional macro TOGGLE_MON_ONES_EN adds per-bit ones counts (out_ones).
module toggle_activity_monitor
    import toggle_mon_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [idx_w(WIDTH)-1:0]   out_idx,
    output logic [CNT_W-1:0]          out_toggles,
    output logic                      out_last
`ifdef TOGGLE_MON_ONES_EN
   ,output logic [CNT_W-1:0]          out_ones
`endif
);

    localparam int IW = idx_w(WIDTH);
    localparam int SW = $clog2(WINDOW + 1);
    localparam logic [SW-1:0] LAST_S = SW'(WINDOW - 1);
    localparam logic [IW-1:0] LAST_I = IW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_prev;
    logic [SW-1:0]    r_samp;
    logic [IW-1:0]    r_idx;

    logic             w_clr;
    logic             w_take;
    logic             w_acc;
    logic             w_hs;
    logic             w_done_s;
    logic             w_done_d;
    logic [CNT_W-1:0] w_tog [WIDTH];
    logic [CNT_W-1:0] w_tsel;

    assign w_clr    = (r_state == IDLE) && start;
    assign w_take   = in_valid && ((r_state == PRIME) || (r_state == COUNT));
    assign w_acc    = in_valid && (r_state == COUNT);
    assign w_hs     = (r_state == DRAIN) && out_ready;
    assign w_done_s = w_acc && (r_samp == LAST_S);
    assign w_done_d = w_hs && (r_idx == LAST_I);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)    w_next = PRIME;
            PRIME:   if (in_valid) w_next = COUNT;
            COUNT:   if (w_done_s) w_next = DRAIN;
            DRAIN:   if (w_done_d) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= '0;
            r_samp  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) r_prev <= in_data;
            if (w_clr) begin
                r_samp <= '0;
            end else if (w_acc) begin
                r_samp <= r_samp + SW'(1);
            end
            if (w_hs) r_idx <= w_done_d ? '0 : r_idx + IW'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_tog
        sat_counter #(.CNT_W(CNT_W)) u_tog (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clr),
            .inc   (w_acc && (in_data[g] ^ r_prev[g])),
            .count (w_tog[g])
        );
    end

    always_comb begin
        w_tsel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_idx == IW'(i)) w_tsel = w_tog[i];
        end
    end

    assign busy        = (r_state != IDLE);
    assign out_valid   = (r_state == DRAIN);
    assign out_idx     = r_idx;
    assign out_toggles = out_valid ? w_tsel : '0;
    assign out_last    = out_valid && (r_idx == LAST_I);

`ifdef TOGGLE_MON_ONES_EN
    logic [CNT_W-1:0] w_one [WIDTH];
    logic [CNT_W-1:0] w_osel;

    // The PRIME sample contributes to ones counts, unlike toggles.
    for (genvar g = 0; g < WIDTH; g++) begin : g_one
        sat_counter #(.CNT_W(CNT_W)) u_one (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clr),
            .inc   (w_take && in_data[g]),
            .count (w_one[g])
        );
    end

    always_comb begin
        w_osel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_idx == IW'(i)) w_osel = w_one[i];
        end
    end

    assign out_ones = out_valid ? w_osel : '0;
`endif

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench for toggle_activity_monitor with a sample-list reference model.
module tb_toggle_activity_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start_b, in_valid, out_ready;
    logic [3:0] in_data;

    logic        busy, out_valid, out_last;
    logic [1:0]  out_idx;
    logic [15:0] out_toggles;
    logic        busy_b, out_valid_b, out_last_b;
    logic [1:0]  out_idx_b;
    logic [1:0]  out_toggles_b;
`ifdef TOGGLE_MON_ONES_EN
    logic [15:0] out_ones;
    logic [1:0]  out_ones_b;
`endif

    toggle_activity_monitor #(.WIDTH(4), .CNT_W(16), .WINDOW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx),
        .out_toggles(out_toggles), .out_last(out_last)
`ifdef TOGGLE_MON_ONES_EN
       ,.out_ones(out_ones)
`endif
    );

    toggle_activity_monitor #(.WIDTH(4), .CNT_W(2), .WINDOW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid),
        .in_data(in_data), .busy(busy_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_idx(out_idx_b),
        .out_toggles(out_toggles_b), .out_last(out_last_b)
`ifdef TOGGLE_MON_ONES_EN
       ,.out_ones(out_ones_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: counts derived from the list of accepted samples.
    logic [3:0] q[$];
    logic [3:0] pat[5];
    int exp_tog[4];
    int exp_one[4];
    int expb[4];

    function automatic void model(input int mx);
        for (int i = 0; i < 4; i++) begin
            int t = 0;
            int o = 0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k][i]) o++;
                if (k > 0 && q[k][i] != q[k-1][i]) t++;
            end
            exp_tog[i] = (t > mx) ? mx : t;
            exp_one[i] = (o > mx) ? mx : o;
        end
    endfunction

    bit mon_en = 0;
    int meas_id = 0;
    int seen_id = 0;
    bit mdl_drain = 0;
    int mdl_beat = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (meas_id != seen_id) begin
                seen_id = meas_id;
                mdl_drain = 1;
                mdl_beat = 0;
            end
            chk("out_valid", out_valid, mdl_drain);
            if (mdl_drain && out_valid) begin
                chk("out_idx", out_idx, mdl_beat);
                chk("out_toggles", out_toggles, exp_tog[mdl_beat]);
                chk("out_last", out_last, mdl_beat == 3);
`ifdef TOGGLE_MON_ONES_EN
                chk("out_ones", out_ones, exp_one[mdl_beat]);
`endif
                if (out_ready) begin
                    mdl_beat++;
                    if (mdl_beat == 4) mdl_drain = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input int gap);
        start = 1;
        tick();
        start = 0;
        q.delete();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1;
            in_data = pat[k];
            q.push_back(pat[k]);
            tick();
            in_valid = 0;
            if (k < 4) repeat (gap) tick();
        end
        model(65535);
        meas_id++;
    endtask

    task automatic drain_a(input int stall, input bit start_mid, input bit start_last);
        int n = 0;
        out_ready = (stall == 0);
        repeat (stall) begin
            if (start_mid) start = 1;
            tick();
            start = 0;
            n++;
        end
        out_ready = 1;
        while (!(seen_id == meas_id && !mdl_drain) && n < 60) begin
            if (start_last && mdl_drain && mdl_beat == 3) start = 1;
            tick();
            start = 0;
            n++;
        end
        chk("drain_timeout", n < 60, 1);
        chk("busy_after_drain", busy, 0);
    endtask

    task automatic run_b();
        start_b = 1;
        tick();
        start_b = 0;
        q.delete();
        for (int k = 0; k < 9; k++) begin
            in_valid = 1;
            in_data = 4'(k % 2);
            q.push_back(in_data);
            tick();
            in_valid = 0;
        end
        model(3);
        for (int i = 0; i < 4; i++) expb[i] = exp_tog[i];
        chk("model_b_sat", expb[0], 3);
        chk("model_b_zero", expb[1], 0);
        out_ready = 1;
        for (int b = 0; b < 4; b++) begin
            chk("b_valid", out_valid_b, 1);
            chk("b_idx", out_idx_b, b);
            chk("b_toggles", out_toggles_b, expb[b]);
            chk("b_last", out_last_b, b == 3);
            tick();
        end
        chk("b_valid_end", out_valid_b, 0);
        chk("b_busy_end", busy_b, 0);
    endtask

    initial begin
        rst = 1;
        start = 0;
        start_b = 0;
        in_valid = 0;
        in_data = '0;
        out_ready = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_toggles", out_toggles, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 0;
        tick();
        mon_en = 1;

        pat[0] = 4'h0; pat[1] = 4'hF; pat[2] = 4'h0; pat[3] = 4'hF; pat[4] = 4'h0;
        run_a(0);
        chk("model_t1_b0", exp_tog[0], 4);
        chk("model_t1_b3", exp_tog[3], 4);
        chk("model_ones_b0", exp_one[0], 2);
        drain_a(0, 0, 0);

        run_a(1);
        drain_a(0, 0, 0);
        run_a(3);
        drain_a(0, 0, 0);

        run_a(0);
        drain_a(5, 1, 1);

        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1;
            in_data = pat[k];
            tick();
        end
        in_valid = 0;
        chk("mid_busy", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        tick();
        chk("abort_busy2", busy, 0);

        pat[0] = 4'h0; pat[1] = 4'h1; pat[2] = 4'h1; pat[3] = 4'h1; pat[4] = 4'h1;
        run_a(0);
        chk("model_t4_b0", exp_tog[0], 1);
        chk("model_t4_b1", exp_tog[1], 0);
        drain_a(0, 0, 0);

        run_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
- Downstream observation stage for the power sub-circuit benchmarks.
- Samples the WIDTH-bit output vector of a combinational circuit-under-test (e.g. primary outputs such as n_7) once per accepted sample.
- Counts per-bit 0->1 and 1->0 transitions over a fixed window of WINDOW comparisons.
- Streams the per-bit toggle counts out one bit index at a time over a valid/ready handshake, feeding the switching-activity/power estimation flow.

Parameters:
- WIDTH, 4, number of monitored signals (>=1)
- CNT_W, 16, width of each per-bit toggle counter (>=1)
- WINDOW, 1024, number of sample-to-sample comparisons per measurement (>=1)

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a measurement; honoured only in IDLE
- in_valid  input  1  in_data valid this cycle
- in_data  input  WIDTH  sampled outputs of circuit-under-test
- busy  output  1  high in any state other than IDLE
- out_valid  output  1  result beat available
- out_ready  input  1  consumer accepts beat
- out_idx  output  max(1,$clog2(WIDTH))  bit index of current beat
- out_toggles  output  CNT_W  toggle count for bit out_idx
- out_last  output  1  high with the beat where out_idx==WIDTH-1

Behaviour:
- Reset (synchronous, active-high; clk is the only clock):
  - state=IDLE; busy, out_valid, out_last=0; out_idx=0; out_toggles=0; all counters, sample counter and previous-sample register cleared.
  - Reset asserted mid-operation aborts the measurement with no partial output.
- States: IDLE -> PRIME -> COUNT -> DRAIN -> IDLE.
- IDLE: start=1 clears all toggle counters and the sample counter -> PRIME next cycle. in_valid is ignored.
- PRIME: first cycle with in_valid=1 stores in_data as prev and counts no toggles -> COUNT.
- COUNT: each cycle with in_valid=1:
  - toggles[i] += (in_data[i]^prev[i]), saturating at 2^CNT_W-1.
  - prev <= in_data; sample counter increments.
  - When the accepted sample is the WINDOW-th comparison, go to DRAIN the next cycle.
  - in_valid=0 cycles change nothing.
- DRAIN:
  - out_valid=1; out_idx starts at 0; out_toggles=toggles[out_idx]; out_last=(out_idx==WIDTH-1).
  - On out_valid&&out_ready: idx increments. The handshake on the last beat -> IDLE with out_valid=0 the next cycle.
  - While out_ready=0, out_idx, out_toggles and out_last hold stable.
- start outside IDLE is ignored. start in the same cycle as the final DRAIN handshake is also ignored.
- Counters hold their values after DRAIN until the next start.
- Latency: first out_valid appears 1 cycle after the final COUNT sample is accepted. Minimum measurement is 1 (start) + 1 (prime) + WINDOW + WIDTH cycles.

Optional Feature:
- Macro TOGGLE_MON_ONES_EN.
- Defined:
  - Adds output out_ones [CNT_W], a per-bit count of cycles with in_data[i]=1 over every accepted sample, including the PRIME sample (WINDOW+1 samples total), saturating.
  - Cleared on start and reset; presented alongside out_toggles with identical handshake timing.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package toggle_mon_pkg holds:
  - state enum (IDLE, PRIME, COUNT, DRAIN)
  - index-width helper function
  - saturation-max constant function of CNT_W
- Sub-module sat_counter (parameter CNT_W; ports clk, rst, clr, inc; output count) implements one saturating counter. It is instantiated WIDTH times for toggles and, under the macro, WIDTH times for ones.

Test Plan:
- WIDTH=4, WINDOW=4: start; samples 0000,1111,0000,1111,0000 back-to-back -> 4 beats, idx 0..3, each toggles=4; out_last on idx 3; then busy=0.
- Same stimulus with in_valid=0 inserted between every sample -> identical counts (4 each); gaps never counted; DRAIN begins 1 cycle after the 5th accepted sample.
- CNT_W=2, WINDOW=8: bit0 alternates, bits1-3 constant 0 -> idx0 toggles=3 (saturated); idx1..3 = 0.
- Backpressure: hold out_ready=0 for 5 cycles during DRAIN -> out_valid stays 1, out_idx=0 and out_toggles unchanged; the beat completes when out_ready rises. A start pulse during DRAIN has no effect.
- Reset asserted in COUNT after 2 samples -> next cycle state IDLE, busy=0, out_valid=0. A fresh run with sample 0000 then 0001 x4 (WINDOW=4) -> idx0=1, others 0.
- With TOGGLE_MON_ONES_EN, test 1 stimulus -> out_ones=2 for every bit (samples 2 and 4 of the 5 are 1111).
